// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a big-endian byte stream
// (16-bit word count, data words, 8-bit sum trailer) into word writes.
module imem_loader #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH_WORDS = 128
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t      state, state_next;
    logic [7:0]  count_hi;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  csum;
    logic [15:0] hdr_count;
    logic        accepting;
    logic        xfer;
    logic        last_byte;
    logic        last_word;

    assign hdr_count = {count_hi, in_data};
    assign last_byte = (byte_idx == 2'd3);
    // Word index is 16 bits wide so a full-capacity image never wraps to 0.
    assign last_word = (word_idx == count - 16'd1);

    always_comb begin
        accepting = 1'b0;
        case (state)
            HDR_HI, HDR_LO, DATA, CHECK: accepting = 1'b1;
            default:                     accepting = 1'b0;
        endcase
    end

    assign in_ready = accepting & ~RESET;
    assign xfer     = in_valid & in_ready;
    assign done     = (state == DONE);
    assign error    = (state == ERROR);
    assign cpu_hold = ~done;

    always_ff @(posedge CLOCK) begin
        if (RESET) state <= HDR_HI;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR_HI: if (xfer) state_next = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    if (hdr_count == 16'd0)
                        state_next = CHECK;
                    else if (hdr_count > 16'(DEPTH_WORDS))
                        state_next = ERROR;
                    else
                        state_next = DATA;
                end
            end
            DATA:   if (xfer && last_byte && last_word) state_next = CHECK;
            CHECK:  if (xfer) state_next = (in_data == csum) ? DONE : ERROR;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            count_hi <= '0;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            csum     <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_data  <= '0;
        end else begin
            im_we <= 1'b0;
            if (xfer) begin
                case (state)
                    HDR_HI: count_hi <= in_data;
                    HDR_LO: count    <= hdr_count;
                    DATA: begin
                        csum     <= csum + in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[23:16] <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[7:0]   <= in_data;
                            default: begin
                                im_we    <= 1'b1;
                                im_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
                                im_data  <= {word_buf, in_data};
                                word_idx <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams images with random gaps and compares
// writes, flags and timing against a stream-parsing reference model.
module tb_imem_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 128;

    logic              CLOCK = 1'b0;
    logic              RESET;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 CLOCK = ~CLOCK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    logic [7:0]  stream[$];
    int unsigned xfer_cyc[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int unsigned obs_cyc[$];

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        if (im_we === 1'b1) begin
            obs_addr.push_back(32'(im_addr));
            obs_data.push_back(im_data);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        xfer_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge CLOCK); #1;
        RESET    = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge CLOCK); #1; end
        RESET = 1'b0;
        clear_obs();
    endtask

    task automatic build_image(input int unsigned nwords, input int unsigned delta);
        logic [7:0] b;
        logic [7:0] sum;
        stream.delete();
        stream.push_back(8'(nwords >> 8));
        stream.push_back(8'(nwords));
        sum = 8'h00;
        for (int unsigned k = 0; k < nwords * 4; k++) begin
            b = 8'($urandom);
            stream.push_back(b);
            sum = sum + b;
        end
        stream.push_back(sum + 8'(delta));
    endtask

    // Presents the stream byte by byte; stops at the first byte refused for 4 cycles.
    task automatic send_stream(input int unsigned max_gap, output int unsigned acc,
                               output int unsigned gaps);
        int unsigned g;
        int unsigned tries;
        logic        ok;
        acc  = 0;
        gaps = 0;
        foreach (stream[i]) begin
            g = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge CLOCK); #1;
                gaps++;
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            tries    = 0;
            ok       = 1'b0;
            while (!ok && tries < 4) begin
                @(negedge CLOCK);
                ok = in_ready;
                @(posedge CLOCK); #1;
                tries++;
            end
            if (!ok) break;
            xfer_cyc.push_back(cyc);
            acc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_image(input string name, input int unsigned max_gap);
        int unsigned cnt, exp_acc, exp_n, acc, gaps, start, nw;
        logic [7:0]  sum;
        logic        exp_done;
        logic [31:0] exp_word;
        cnt = int'(stream[0]) * 256 + int'(stream[1]);
        if (cnt > DEPTH) begin
            exp_acc  = 2;
            exp_n    = 0;
            exp_done = 1'b0;
        end else begin
            exp_n = cnt;
            sum   = 8'h00;
            for (int unsigned k = 0; k < cnt * 4; k++) sum = sum + stream[2 + k];
            exp_acc  = 3 + 4 * cnt;
            exp_done = (stream[2 + 4 * cnt] == sum);
        end
        start = cyc;
        send_stream(max_gap, acc, gaps);
        check({name, ".accepted"}, acc, exp_acc);
        @(negedge CLOCK);
        check({name, ".done"}, 32'(done), 32'(exp_done));
        check({name, ".error"}, 32'(error), 32'(!exp_done));
        check({name, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({name, ".in_ready"}, 32'(in_ready), 0);
        if (acc == stream.size())
            check({name, ".cycles"}, xfer_cyc[xfer_cyc.size() - 1] - start, acc + gaps);
        repeat (3) @(negedge CLOCK);
        check({name, ".sticky"}, {30'd0, done, error}, {30'd0, exp_done, !exp_done});
        check({name, ".nwrites"}, obs_addr.size(), exp_n);
        nw = (obs_addr.size() < exp_n) ? obs_addr.size() : exp_n;
        for (int unsigned k = 0; k < nw; k++) begin
            exp_word = {stream[2 + 4 * k], stream[3 + 4 * k], stream[4 + 4 * k], stream[5 + 4 * k]};
            check({name, ".addr"}, obs_addr[k], k * 4);
            check({name, ".data"}, obs_data[k], exp_word);
            if (acc == exp_acc)
                check({name, ".wr_cycle"}, obs_cyc[k], xfer_cyc[5 + 4 * k]);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".in_ready"}, 32'(in_ready), 0);
        check({name, ".im_we"}, 32'(im_we), 0);
        check({name, ".im_addr"}, 32'(im_addr), 0);
        check({name, ".im_data"}, im_data, 0);
        check({name, ".cpu_hold"}, 32'(cpu_hold), 1);
        check({name, ".done"}, 32'(done), 0);
        check({name, ".error"}, 32'(error), 0);
    endtask

    int unsigned acc_mid, gaps_mid;

    initial begin
        RESET    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge CLOCK); #1;
        @(negedge CLOCK);
        check_reset_values("reset");
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("reset.ready_rise", 32'(in_ready), 1);
        @(posedge CLOCK); #1;
        clear_obs();

        stream = '{8'h00, 8'h01, 8'h81, 8'hC3, 8'hE0, 8'h08, 8'h2C};
        run_image("single", 0);
        if (obs_data.size() > 0) check("single.word", obs_data[0], 32'h81C3E008);

        do_reset();
        stream = '{8'h00, 8'h00, 8'h00};
        run_image("empty_ok", 2);

        do_reset();
        stream = '{8'h00, 8'h00, 8'h05};
        run_image("empty_bad", 0);

        do_reset();
        stream = '{8'h00, 8'h81, 8'h11, 8'h22, 8'h33, 8'h44};
        run_image("overflow", 0);

        do_reset();
        build_image(DEPTH, 0);
        run_image("full", 3);

        do_reset();
        build_image(2, 1);
        run_image("mismatch", 1);

        // Reset after two bytes of the third word of a 4-word image.
        do_reset();
        build_image(4, 0);
        stream = stream[0:11];
        send_stream(1, acc_mid, gaps_mid);
        check("midload.accepted", acc_mid, 12);
        check("midload.nwrites", obs_addr.size(), 2);
        RESET = 1'b1;
        @(negedge CLOCK);
        check("midload.ready_in_reset", 32'(in_ready), 0);
        @(posedge CLOCK); #1;
        @(negedge CLOCK);
        check_reset_values("midload");
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        check("midload.ready_rise", 32'(in_ready), 1);
        @(posedge CLOCK); #1;
        clear_obs();
        build_image(1, 0);
        run_image("reload", 0);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            build_image($urandom_range(12, 0), ($urandom_range(3, 0) == 0) ? 1 : 0);
            run_image("random", 3);
        end

        do_reset();
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        run_image("overflow_hi", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
